// File: rtl/tt_um_csa_bist.sv
// Built-in self-test for a 4-bit carry-select adder. Applies exhaustive or
// LFSR-generated vectors through a two-stage pipeline and compares each
// result against a behavioural reference. Reports pass/fail, a saturating
// error count and the index of the first failing vector.
module tt_um_csa_bist (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_enter;
  logic        w_last;

  logic        r_start_s;
  logic        r_start_p;
  logic        w_start_edge;

  logic        r_mode;
  logic [8:0]  r_gen;
  logic [9:0]  r_cyc;
  logic [9:0]  w_nvec;
  logic        w_issue;
  logic [8:0]  w_gen_next;

  logic [3:0]  r_a1;
  logic [3:0]  r_b1;
  logic        r_cin1;
  logic [8:0]  r_k1;
  logic        r_v1;

  logic [4:0]  r_dut2;
  logic [4:0]  r_ref2;
  logic [8:0]  r_k2;
  logic        r_v2;

  logic [3:0]  r_err;
  logic        r_fail;
  logic [7:0]  r_ffidx;

  logic [2:0]  w_lo;
  logic [2:0]  w_hi0;
  logic [2:0]  w_hi1;
  logic [4:0]  w_dut;
  logic [4:0]  w_ref;
  logic        w_mismatch;

  logic        w_unused;
  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

  assign uio_oe = 8'hFF;

  // Start is registered once, then edge-detected against its previous sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s <= 1'b0;
      r_start_p <= 1'b0;
    end else begin
      r_start_s <= ui_in[0];
      r_start_p <= r_start_s;
    end
  end

  assign w_start_edge = r_start_s & ~r_start_p;

  // Vector count depends on the mode latched at RUN entry
  assign w_nvec  = r_mode ? 10'd511 : 10'd512;
  assign w_issue = (r_cyc < w_nvec);
  assign w_last  = (r_cyc == w_nvec + 10'd1);

  // Carry-select adder under test: upper block precomputed for both carries
  always_comb begin
    w_lo  = {1'b0, r_a1[1:0]} + {1'b0, r_b1[1:0]} + {2'b00, r_cin1};
    w_hi0 = {1'b0, r_a1[3:2]} + {1'b0, r_b1[3:2]};
    w_hi1 = {1'b0, r_a1[3:2]} + {1'b0, r_b1[3:2]} + 3'd1;
    w_dut = w_lo[2] ? {w_hi1, w_lo[1:0]} : {w_hi0, w_lo[1:0]};
    w_ref = {1'b0, r_a1} + {1'b0, r_b1} + {4'b0000, r_cin1};
  end

  assign w_mismatch = (r_dut2 != r_ref2);

  // Next generator value: counter in exhaustive mode, Fibonacci LFSR otherwise
  assign w_gen_next = r_mode ? {r_gen[7:0], r_gen[8] ^ r_gen[4]} : r_gen + 9'd1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state; start edges seen during RUN are ignored
  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_edge) begin
          w_next  = S_RUN;
          w_enter = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Vector generation, pipeline stages and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= 1'b0;
      r_gen   <= '0;
      r_cyc   <= '0;
      r_a1    <= '0;
      r_b1    <= '0;
      r_cin1  <= 1'b0;
      r_k1    <= '0;
      r_v1    <= 1'b0;
      r_dut2  <= '0;
      r_ref2  <= '0;
      r_k2    <= '0;
      r_v2    <= 1'b0;
      r_err   <= '0;
      r_fail  <= 1'b0;
      r_ffidx <= '0;
    end else if (w_enter) begin
      r_mode  <= ui_in[1];
      r_gen   <= ui_in[1] ? 9'h001 : 9'h000;
      r_cyc   <= '0;
      r_k1    <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_err   <= '0;
      r_fail  <= 1'b0;
      r_ffidx <= '0;
    end else if (r_state == S_RUN) begin
      r_cyc <= r_cyc + 10'd1;
      if (w_issue) begin
        r_a1   <= r_gen[3:0];
        r_b1   <= r_gen[7:4];
        r_cin1 <= r_gen[8];
        r_k1   <= r_cyc[8:0];
        r_v1   <= 1'b1;
        r_gen  <= w_gen_next;
      end else begin
        r_v1   <= 1'b0;
      end
      r_dut2 <= w_dut ^ {4'b0000, ui_in[2]};
      r_ref2 <= w_ref;
      r_k2   <= r_k1;
      r_v2   <= r_v1;
      if (r_v2 && w_mismatch) begin
        r_fail <= 1'b1;
        if (r_err != 4'hF) r_err <= r_err + 4'd1;
        if (!r_fail) r_ffidx <= r_k2[7:0];
      end
    end
  end

  // Status outputs decoded from state
  always_comb begin
    uo_out  = '0;
    uio_out = '0;
    case (r_state)
      S_RUN: begin
        uo_out  = {r_err, r_fail, 1'b0, 1'b0, 1'b1};
        uio_out = r_k1[7:0];
      end
      S_DONE: begin
        uo_out  = {r_err, r_fail, ~r_fail, 1'b1, 1'b0};
        uio_out = r_ffidx;
      end
      default: begin
        uo_out  = '0;
        uio_out = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tt_um_csa_bist.sv
// Self-checking bench for tt_um_csa_bist: table of complete runs plus
// hand-written sequences for single-vector fault, mid-run reset and held start.
module tb_tt_um_csa_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  tt_um_csa_bist dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode;
    bit fault;
    int busy;
    int pass;
    int fail;
    int err;
    int uio;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pulses (or holds) start, then follows the run one negedge per cycle.
  // j indexes RUN cycles; fault is raised during cycle fault_on only, and
  // reset is asserted at cycle abort_at (task returns immediately).
  task automatic run_seq(input bit mode, input bit fault, input bit hold,
                         input int fault_on, input int abort_at,
                         output int busy_n, output int err_at0, output int uio_at38);
    bit found;
    int j;
    found    = 1'b0;
    busy_n   = 0;
    err_at0  = -1;
    uio_at38 = -1;
    ui_in    = {5'b00000, fault, mode, 1'b1};
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (uo_out[0]) found = 1'b1;
    end
    if (!hold) ui_in[0] = 1'b0;
    if (!found) begin
      chk("busy_rise", 0, 1);
      return;
    end
    j = 0;
    while (uo_out[0] && j < 1000) begin
      if (j == 0) err_at0 = int'(uo_out[7:4]);
      if (j == 38) uio_at38 = int'(uio_out);
      if (j == abort_at) begin
        rst_n  = 1'b0;
        busy_n = j;
        return;
      end
      if (j == fault_on) ui_in[2] = 1'b1;
      if (j == fault_on + 1) ui_in[2] = 1'b0;
      busy_n++;
      j++;
      @(negedge clk);
    end
  endtask

  task automatic check_done(input string tag, input int pass, input int fail,
                            input int err, input int uio);
    chk({tag, "_done"}, int'(uo_out[1]), 1);
    chk({tag, "_pass"}, int'(uo_out[2]), pass);
    chk({tag, "_fail"}, int'(uo_out[3]), fail);
    chk({tag, "_err"},  int'(uo_out[7:4]), err);
    chk({tag, "_uio"},  int'(uio_out), uio);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, e0, u38;

    tbl[0] = '{mode: 1'b0, fault: 1'b0, busy: 514, pass: 1, fail: 0, err: 0,  uio: 8'h00};
    tbl[1] = '{mode: 1'b1, fault: 1'b0, busy: 513, pass: 1, fail: 0, err: 0,  uio: 8'h00};
    tbl[2] = '{mode: 1'b0, fault: 1'b1, busy: 514, pass: 0, fail: 1, err: 15, uio: 8'h00};
    tbl[3] = '{mode: 1'b1, fault: 1'b1, busy: 513, pass: 0, fail: 1, err: 15, uio: 8'h00};

    // Reset state
    #1;
    chk("rst_uo",  int'(uo_out), 0);
    chk("rst_uio", int'(uio_out), 0);
    chk("rst_oe",  int'(uio_oe), 8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_uo", int'(uo_out), 0);

    // Table of full runs
    for (int r = 0; r < 4; r++) begin
      run_seq(tbl[r].mode, tbl[r].fault, 1'b0, 9999, 9999, bn, e0, u38);
      chk($sformatf("t%0d_busy", r), bn, tbl[r].busy);
      check_done($sformatf("t%0d", r), tbl[r].pass, tbl[r].fail, tbl[r].err, tbl[r].uio);
      ui_in = '0;
      repeat (3) @(negedge clk);
    end

    // Single fault on vector k=37 (captured at stage 2 during RUN cycle 38)
    run_seq(1'b0, 1'b0, 1'b0, 38, 9999, bn, e0, u38);
    chk("k37_busy", bn, 514);
    chk("k37_idx_in_run", u38, 37);
    check_done("k37", 0, 1, 1, 8'h25);
    ui_in = '0;
    repeat (3) @(negedge clk);

    // Reset at RUN cycle 100 aborts immediately
    run_seq(1'b0, 1'b0, 1'b0, 9999, 100, bn, e0, u38);
    chk("abort_cycle", bn, 100);
    #1;
    chk("abort_uo",  int'(uo_out), 0);
    chk("abort_uio", int'(uio_out), 0);
    chk("abort_oe",  int'(uio_oe), 8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", int'(uo_out), 0);
    run_seq(1'b0, 1'b0, 1'b0, 9999, 9999, bn, e0, u38);
    chk("after_abort_busy", bn, 514);
    check_done("after_abort", 1, 0, 0, 8'h00);
    ui_in = '0;
    repeat (3) @(negedge clk);

    // Start held through a faulty run: exactly one run, then re-pulse
    run_seq(1'b0, 1'b1, 1'b1, 9999, 9999, bn, e0, u38);
    chk("held_busy", bn, 514);
    repeat (6) @(negedge clk);
    chk("held_no_rerun", int'(uo_out[0]), 0);
    check_done("held", 0, 1, 15, 8'h00);
    ui_in = '0;
    repeat (3) @(negedge clk);
    run_seq(1'b0, 1'b0, 1'b0, 9999, 9999, bn, e0, u38);
    chk("rerun_err_at_entry", e0, 0);
    chk("rerun_busy", bn, 514);
    check_done("rerun", 1, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
